// File: rtl/mem_access_ctrl.sv
// Data-memory access controller for the EX/MEM stage: issues one aligned request,
// stalls the pipeline until it completes, resolves branches, and latches faults.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        exmem_memread,
   input  logic        exmem_memwrite,
   input  logic        exmem_branch,
   input  logic        exmem_zf,
   input  logic [31:0] exmem_alu,
   input  logic [31:0] exmem_b2,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        stall,
   output logic [31:0] rdata_out,
   output logic        rdata_valid,
   output logic        pc_src,
   output logic        flush,
   output logic        err,
   output logic        err_align
);

   typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;
   logic [31:0] rdata_out_q, rdata_out_d;
   logic        rdata_valid_q, rdata_valid_d;
   logic        err_q, err_d;
   logic        err_align_q, err_align_d;
   logic        access;

   assign access = exmem_memread | exmem_memwrite;

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      mem_req_d     = mem_req_q;
      mem_we_d      = mem_we_q;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;
      rdata_out_d   = rdata_out_q;
      rdata_valid_d = 1'b0;
      err_d         = err_q;
      err_align_d   = err_align_q;
      case (state_q)
         IDLE: begin
            if (access) begin
               if (exmem_alu[1:0] == 2'b00) begin
                  state_d     = REQ;
                  cnt_d       = 8'd0;
                  mem_req_d   = 1'b1;
                  mem_we_d    = exmem_memwrite;
                  mem_addr_d  = exmem_alu;
                  mem_wdata_d = exmem_b2;
               end else begin
                  state_d     = ERR;
                  err_d       = 1'b1;
                  err_align_d = 1'b1;
               end
            end
         end
         REQ: begin
            // An ack in the timeout cycle still completes the access.
            if (mem_ack) begin
               state_d   = DONE;
               mem_req_d = 1'b0;
               if (!mem_we_q) begin
                  rdata_out_d   = mem_rdata;
                  rdata_valid_d = 1'b1;
               end
            end else if (cnt_q == LAST_WAIT) begin
               state_d     = ERR;
               mem_req_d   = 1'b0;
               err_d       = 1'b1;
               err_align_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = ERR;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= 8'd0;
         mem_req_q     <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= 32'd0;
         mem_wdata_q   <= 32'd0;
         rdata_out_q   <= 32'd0;
         rdata_valid_q <= 1'b0;
         err_q         <= 1'b0;
         err_align_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         mem_req_q     <= mem_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         rdata_out_q   <= rdata_out_d;
         rdata_valid_q <= rdata_valid_d;
         err_q         <= err_d;
         err_align_q   <= err_align_d;
      end
   end

   // DONE drops stall so the held instruction leaves EX/MEM without re-triggering.
   assign stall = ((state_q == IDLE) && access) || (state_q == REQ) || (state_q == ERR);

   assign pc_src      = exmem_branch & exmem_zf & ~stall;
   assign flush       = pc_src;
   assign mem_req     = mem_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign rdata_out   = rdata_out_q;
   assign rdata_valid = rdata_valid_q;
   assign err         = err_q;
   assign err_align   = err_align_q;

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: maximum cycles in REQ without mem_ack before ERR; range 2..255.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 exmem_memread  input  1  the EX/MEM-stage instruction is a load.
REQ-005 exmem_memwrite  input  1  the EX/MEM-stage instruction is a store.
REQ-006 exmem_branch  input  1  the EX/MEM-stage instruction is a branch.
REQ-007 exmem_zf  input  1  zero flag captured with the branch.
REQ-008 exmem_alu  input  32  effective byte address.
REQ-009 exmem_b2  input  32  store data.
REQ-010 mem_ack  input  1  data memory completes the outstanding request.
REQ-011 mem_rdata  input  32  load data, valid when mem_ack=1.
REQ-012 mem_req  output  1  request to data memory; registered.
REQ-013 mem_we  output  1  1=write, 0=read; registered.
REQ-014 mem_addr  output  32  request address; registered.
REQ-015 mem_wdata  output  32  request write data; registered.
REQ-016 stall  output  1  freezes the IF/ID, ID/EX and EX/MEM registers and the PC.
REQ-017 rdata_out  output  32  captured load data.
REQ-018 rdata_valid  output  1  one-cycle pulse: rdata_out is valid for a completed load.
REQ-019 pc_src  output  1  branch taken; selects the branch target.
REQ-020 flush  output  1  clears the younger pipeline registers; equals pc_src.
REQ-021 err  output  1  sticky fault indicator.
REQ-022 err_align  output  1  sticky; the fault was a misaligned address (0 = timeout).

Function
REQ-023 FSM states: IDLE, REQ, DONE, ERR.
REQ-024 Define access = exmem_memread | exmem_memwrite; if both are 1, the access is a write.
REQ-025 IDLE, access=1, exmem_alu[1:0]=00: latch addr, wdata and we into the output registers, and go to REQ.
REQ-026 IDLE, access=1, exmem_alu[1:0]!=00: go to ERR with err_align=1; issue no request.
REQ-027 IDLE, access=0: remain in IDLE; mem_ack is ignored.
REQ-028 stall is combinational: 1 when (IDLE and access=1), or in REQ, or in ERR; 0 in DONE and otherwise.
REQ-029 mem_req is 1 exactly while in REQ; mem_addr, mem_wdata and mem_we stay stable throughout REQ.
REQ-030 REQ, mem_ack=1: on a read, capture mem_rdata into rdata_out; go to DONE.
REQ-031 REQ has an 8-bit wait counter, cleared on entry and incremented each cycle without ack.
REQ-032 REQ, no ack and counter=TIMEOUT-1: go to ERR with err_align=0.
REQ-033 mem_ack arriving in the same cycle as the timeout wins; the access completes normally.
REQ-034 DONE lasts one cycle:
- rdata_valid=1 only if the access was a read;
- the pipeline advances;
- the held instruction is not re-evaluated;
- the next state is always IDLE.
REQ-035 ERR is terminal until reset: stall=1, err=1, mem_req=0.
REQ-036 pc_src = exmem_branch & exmem_zf & ~stall; combinational.
REQ-037 A branch flagged together with an access is resolved only in the cycle stall is 0.
REQ-038 Minimum stall for an access is 2 cycles (detect cycle plus a REQ cycle with immediate ack); each REQ cycle without ack adds 1.

Reset
REQ-039 rst_n=0 asynchronously forces:
- state=IDLE, counter=0;
- mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
- rdata_out=0, rdata_valid=0, err=0, err_align=0.
REQ-040 Reset asserted in REQ drops mem_req immediately, without waiting for a clock edge; a late mem_ack after reset is ignored.
REQ-041 After rst_n deasserts, the first evaluation is at the next rising edge, from IDLE.

Verification
REQ-042 Load, addr 0x0000_0010, ack on the first REQ cycle with rdata 0xDEAD_BEEF -> stall high for 2 cycles, then rdata_valid pulses with rdata_out=0xDEAD_BEEF.
REQ-043 Store, addr 0x20, data 0x1234_5678, ack after 3 wait cycles -> mem_we=1, address and data stable for 4 REQ cycles, rdata_valid stays 0.
REQ-044 Load with no ack, TIMEOUT=16 -> ERR after 16 REQ cycles, err=1, err_align=0, stall held at 1.
REQ-045 Load at addr 0x0000_0003 -> ERR on the next edge, err_align=1, mem_req never asserted.
REQ-046 Branch with zf=1 and no access -> pc_src=flush=1 in the same cycle; zf=0 -> both stay 0.
REQ-047 rst_n pulsed low mid-REQ -> mem_req falls asynchronously, all outputs at reset values, and the next load completes normally.
